// File: rtl/spi_pkg.sv
// Shared types and sizes for the 16-bit SPI responder.
package spi_pkg;

    localparam int unsigned SPI_WIDTH = 16;
    localparam int unsigned SPI_CNT_W = 5;

    typedef enum logic {
        IDLE,
        XFER
    } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous input, plus an extra flop that
// provides rise/fall detection on the last two synchronized samples.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{RST_VAL}};
            prev  <= RST_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign sync = chain[STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/spi_slv16.sv
// 16-bit SPI responder: SCLK idles high, MOSI captured on rise, MISO shifted on fall.
// Optional macro SPI_SLV_TRISTATE_EN releases MISO to z while SS_n is high.
module spi_slv16
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned WIDTH       = SPI_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             SS_n,
    input  logic             SCLK,
    input  logic             MOSI,
    output logic             MISO,
    input  logic             wrt,
    input  logic [WIDTH-1:0] tx_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rdy,
    input  logic             clr_rdy,
    output logic             frm_err
);

    localparam logic [SPI_CNT_W-1:0] CNT_FULL = SPI_CNT_W'(WIDTH);

    spi_slv_state_t state, state_nxt;

    logic                 ss_s, ss_rise, ss_fall;
    logic                 sclk_s, sclk_rise, sclk_fall;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                 mosi_s;

    logic [WIDTH-1:0]     tx_buf, tx_buf_nxt;
    logic [WIDTH-1:0]     shft, shft_nxt;
    logic                 smpl, smpl_nxt;
    logic [SPI_CNT_W-1:0] bit_cnt, bit_cnt_nxt;
    logic [WIDTH-1:0]     rd_data_nxt;
    logic                 rdy_nxt, frm_err_nxt;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SS_n),
        .sync  (ss_s),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (SCLK),
        .sync  (sclk_s),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // Same depth as the SCLK chain so mosi_s lines up with sclk_rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mosi_q <= '0;
        else        mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
    end
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        tx_buf_nxt  = wrt ? tx_data : tx_buf;
        shft_nxt    = shft;
        smpl_nxt    = smpl;
        bit_cnt_nxt = bit_cnt;
        rd_data_nxt = rd_data;
        rdy_nxt     = clr_rdy ? 1'b0 : rdy;
        frm_err_nxt = 1'b0;
        unique case (state)
            IDLE: begin
                if (ss_fall) begin
                    shft_nxt    = wrt ? tx_data : tx_buf;
                    bit_cnt_nxt = '0;
                    rdy_nxt     = 1'b0;
                    state_nxt   = XFER;
                end
            end
            XFER: begin
                // ss_rise takes priority; an SCLK edge in the same clk is dropped.
                if (ss_rise) begin
                    if (bit_cnt == CNT_FULL) begin
                        rd_data_nxt = {shft[WIDTH-2:0], smpl};
                        rdy_nxt     = 1'b1;
                    end else begin
                        frm_err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end else if (!ss_s && sclk_rise) begin
                    smpl_nxt = mosi_s;
                    if (bit_cnt != '1) bit_cnt_nxt = bit_cnt + SPI_CNT_W'(1);
                end else if (!ss_s && sclk_fall && bit_cnt != '0) begin
                    shft_nxt = {shft[WIDTH-2:0], smpl};
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_buf  <= '0;
            shft    <= '0;
            smpl    <= 1'b0;
            bit_cnt <= '0;
            rd_data <= '0;
            rdy     <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            tx_buf  <= tx_buf_nxt;
            shft    <= shft_nxt;
            smpl    <= smpl_nxt;
            bit_cnt <= bit_cnt_nxt;
            rd_data <= rd_data_nxt;
            rdy     <= rdy_nxt;
            frm_err <= frm_err_nxt;
        end
    end

`ifdef SPI_SLV_TRISTATE_EN
    assign MISO = ss_s ? 1'bz : shft[WIDTH-1];
`else
    assign MISO = shft[WIDTH-1];
`endif

endmodule

// File: tb/tb_spi_slv16.sv
// Bench for spi_slv16: behavioural 16-bit SPI master at clk = 32x SCLK,
// vector table for the directed frames plus randomized frames against a word-level model.
module tb_spi_slv16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        SS_n = 1'b1;
    logic        SCLK = 1'b1;
    logic        MOSI = 1'b0;
    wire         MISO;
    logic        wrt = 1'b0;
    logic [15:0] tx_data = '0;
    logic [15:0] rd_data;
    logic        rdy;
    logic        clr_rdy = 1'b0;
    logic        frm_err;

    int errors = 0;
    int checks = 0;
    int frm_err_cnt = 0;

    // Word-level model: what the slave should hold / return.
    logic [15:0] m_tx_buf = '0;
    logic [15:0] m_frame_tx = '0;
    logic [15:0] m_rd = '0;

    typedef struct {
        logic [15:0] tx;
        logic [15:0] rx;
        int          rises;
        logic [15:0] exp_rd;
        logic        exp_rdy;
        int          exp_ferr;
        logic [15:0] exp_mread;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    spi_slv16 #(.SYNC_STAGES(2), .WIDTH(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .SS_n    (SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .wrt     (wrt),
        .tx_data (tx_data),
        .rd_data (rd_data),
        .rdy     (rdy),
        .clr_rdy (clr_rdy),
        .frm_err (frm_err)
    );

    always @(negedge clk) if (frm_err === 1'b1) frm_err_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic write_tx(input logic [15:0] v);
        @(negedge clk);
        tx_data = v;
        wrt = 1'b1;
        m_tx_buf = v;
        @(negedge clk);
        wrt = 1'b0;
    endtask

    // Master frame: preamble fall, then `rises` rise/fall bit periods; SS_n rises after the last rise.
    task automatic frame(input logic [15:0] d, input int rises,
                         input bit fall_wrt, input logic [15:0] fall_val,
                         input bit mid_wrt, input logic [15:0] mid_val,
                         input int rst_at, output logic [15:0] got);
        got = '0;
        @(negedge clk);
        SS_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (fall_wrt) begin
            tx_data = fall_val;
            wrt = 1'b1;
            m_tx_buf = fall_val;
        end
        @(negedge clk);
        wrt = 1'b0;
        m_frame_tx = m_tx_buf;
        check("rdy_clr_on_ss_fall", 32'(rdy), 32'd0);
        repeat (13) @(negedge clk);
        SCLK = 1'b0;
        MOSI = d[15];
        repeat (16) @(negedge clk);
        for (int k = 1; k <= rises; k++) begin
            SCLK = 1'b1;
            got = {got[14:0], MISO};
            repeat (16) @(negedge clk);
            if (k == rst_at) begin
                rst_n = 1'b0;
                SS_n = 1'b1;
                SCLK = 1'b1;
                return;
            end
            if (k < rises) begin
                SCLK = 1'b0;
                MOSI = d[15-k];
                if (mid_wrt && k == 8) begin
                    tx_data = mid_val;
                    wrt = 1'b1;
                    m_tx_buf = mid_val;
                end
                @(negedge clk);
                wrt = 1'b0;
                repeat (15) @(negedge clk);
            end
        end
        SS_n = 1'b1;
    endtask

    initial begin
        logic [15:0] got;
        logic [15:0] rnd_rx;
        int ferr0;

        vecs[0] = '{16'h3CF0, 16'hA5C3, 16, 16'hA5C3, 1'b1, 0, 16'h3CF0};
        vecs[1] = '{16'hFFFF, 16'h0001, 16, 16'h0001, 1'b1, 0, 16'hFFFF};
        vecs[2] = '{16'h0000, 16'h8000, 16, 16'h8000, 1'b1, 0, 16'h0000};
        vecs[3] = '{16'h1111, 16'h00FF,  8, 16'h8000, 1'b0, 1, 16'h0011};
        vecs[4] = '{16'h2222, 16'h1234, 16, 16'h1234, 1'b1, 0, 16'h2222};

        repeat (3) @(negedge clk);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        check("reset_rdy", 32'(rdy), 32'd0);
        check("reset_frm_err", 32'(frm_err), 32'd0);
`ifdef SPI_SLV_TRISTATE_EN
        check("reset_miso_z", MISO, 1'bz);
`else
        check("reset_miso", MISO, 1'b0);
`endif
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            write_tx(vecs[i].tx);
            ferr0 = frm_err_cnt;
            frame(vecs[i].rx, vecs[i].rises, 1'b0, '0, 1'b0, '0, 0, got);
            repeat (6) @(negedge clk);
            check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_rd));
            check($sformatf("vec%0d_rdy", i), 32'(rdy), 32'(vecs[i].exp_rdy));
            check($sformatf("vec%0d_frm_err_pulses", i), 32'(frm_err_cnt - ferr0), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d_master_read", i), 32'(got), 32'(vecs[i].exp_mread));
            if (vecs[i].rises == 16) m_rd = vecs[i].rx;
        end

        // wrt in the same clk as the internal ss_fall bypasses tx_buf
        write_tx(16'h1111);
        frame(16'hC0DE, 16, 1'b1, 16'hBEEF, 1'b0, '0, 0, got);
        repeat (6) @(negedge clk);
        check("wrt_at_fall_master_read", 32'(got), 32'(m_frame_tx));
        check("wrt_at_fall_value", 32'(got), 32'h0000BEEF);
        m_rd = 16'hC0DE;
        frame(16'h7E81, 16, 1'b0, '0, 1'b1, 16'h0F0F, 0, got);
        repeat (6) @(negedge clk);
        check("mid_wrt_frame_unaffected", 32'(got), 32'h0000BEEF);
        check("mid_wrt_rd_data", 32'(rd_data), 32'h00007E81);
        m_rd = 16'h7E81;
        frame(16'h0000, 16, 1'b0, '0, 1'b0, '0, 0, got);
        repeat (6) @(negedge clk);
        check("mid_wrt_next_frame", 32'(got), 32'h00000F0F);
        m_rd = 16'h0000;

        // Reset mid-frame at bit 9
        ferr0 = frm_err_cnt;
        frame(16'h6789, 16, 1'b0, '0, 1'b0, '0, 9, got);
        repeat (2) @(negedge clk);
        check("midrst_rd_data", 32'(rd_data), 32'd0);
        check("midrst_rdy", 32'(rdy), 32'd0);
`ifndef SPI_SLV_TRISTATE_EN
        check("midrst_miso", MISO, 1'b0);
`endif
        rst_n = 1'b1;
        m_tx_buf = '0;
        m_rd = '0;
        repeat (4) @(negedge clk);
        check("midrst_no_rdy", 32'(rdy), 32'd0);
        frame(16'h5A5A, 16, 1'b0, '0, 1'b0, '0, 0, got);
        repeat (6) @(negedge clk);
        check("midrst_next_rd_data", 32'(rd_data), 32'h00005A5A);
        check("midrst_next_rdy", 32'(rdy), 32'd1);
        check("midrst_next_master_read", 32'(got), 32'(m_frame_tx));
        check("midrst_no_frm_err", 32'(frm_err_cnt - ferr0), 32'd0);
        m_rd = 16'h5A5A;

        // clr_rdy while idle
        @(negedge clk);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check("clr_rdy_idle", 32'(rdy), 32'd0);

        // clr_rdy in the same clk as the completion set; rdy latency is 3 clks from the pin
        frame(16'h4321, 16, 1'b0, '0, 1'b0, '0, 0, got);
        @(negedge clk);
        @(negedge clk);
        check("rdy_latency_not_yet", 32'(rdy), 32'd0);
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        check("set_beats_clr_rdy", 32'(rdy), 32'd1);
        repeat (3) @(negedge clk);
        check("set_beats_clr_rd_data", 32'(rd_data), 32'h00004321);
        m_rd = 16'h4321;

        // Randomized full frames against the model
        for (int r = 0; r < 16; r++) begin
            if ($urandom_range(0, 1) == 1) write_tx(16'($urandom));
            rnd_rx = 16'($urandom);
            frame(rnd_rx, 16, 1'b0, '0, 1'b0, '0, 0, got);
            m_rd = rnd_rx;
            repeat (6) @(negedge clk);
            check($sformatf("rand%0d_rd_data", r), 32'(rd_data), 32'(m_rd));
            check($sformatf("rand%0d_master_read", r), 32'(got), 32'(m_frame_tx));
            check($sformatf("rand%0d_rdy", r), 32'(rdy), 32'd1);
        end

`ifdef SPI_SLV_TRISTATE_EN
        check("miso_z_ss_high", MISO, 1'bz);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
